// File: rtl/periph_req_bridge.sv
// Registered request stage between a core peripheral port and the peripheral demux.
// Caps in-flight transactions and answers unmapped addresses locally with an error response.
// Optional watchdog: define PERIPH_REQ_BRIDGE_TIMEOUT_EN.
module periph_req_bridge #(
   parameter int unsigned ADDR_WIDTH             = 32,
   parameter int unsigned DATA_WIDTH             = 32,
   parameter int unsigned BE_WIDTH               = DATA_WIDTH/8,
   parameter logic        DEM_PER_BEFORE_TCDM_TS = 1'b0,
   parameter int unsigned MAX_OUTSTANDING        = 2,
   parameter int unsigned TIMEOUT_CYCLES         = 256
) (
   input  logic                  clk,
   input  logic                  rst_ni,
   input  logic                  core_req_i,
   input  logic [ADDR_WIDTH-1:0] core_add_i,
   input  logic                  core_wen_i,
   input  logic [DATA_WIDTH-1:0] core_wdata_i,
   input  logic [BE_WIDTH-1:0]   core_be_i,
   output logic                  core_gnt_o,
   output logic                  core_r_valid_o,
   output logic [DATA_WIDTH-1:0] core_r_rdata_o,
   output logic                  core_r_opc_o,
   output logic                  per_req_o,
   output logic [ADDR_WIDTH-1:0] per_add_o,
   output logic                  per_wen_o,
   output logic [DATA_WIDTH-1:0] per_wdata_o,
   output logic [BE_WIDTH-1:0]   per_be_o,
   input  logic                  per_gnt_i,
   input  logic                  per_r_valid_i,
   input  logic [DATA_WIDTH-1:0] per_r_rdata_i,
   input  logic                  per_r_opc_i,
   output logic                  timeout_o
);

   localparam int unsigned CNT_W = 4;
   localparam int unsigned IFL_W = CNT_W + 1;

   logic                  stage_valid;
   logic [ADDR_WIDTH-1:0] add_q;
   logic                  wen_q;
   logic [DATA_WIDTH-1:0] wdata_q;
   logic [BE_WIDTH-1:0]   be_q;
   logic [CNT_W-1:0]      out_cnt;
   logic                  err_pend;

   logic                  mapped_c;
   logic [IFL_W-1:0]      in_flight_c;
   logic                  acc_map_c;
   logic                  acc_err_c;
   logic                  cnt_inc_c;
   logic                  unused_c;

   // Address decode; must agree with the downstream demux map
   always_comb begin
      mapped_c = 1'b0;
      if (DEM_PER_BEFORE_TCDM_TS) begin
         mapped_c = (core_add_i[13:10] == 4'hF) || (core_add_i[13:10] == 4'hE);
      end else begin
         mapped_c = (core_add_i[19:14] == 6'b000001) &&
                    ((core_add_i[13:10] == 4'h0) || (core_add_i[13:10] == 4'h1));
      end
   end

   assign unused_c = ^core_add_i;

   assign in_flight_c = IFL_W'(out_cnt) + IFL_W'(stage_valid);
   assign acc_map_c   = core_req_i & mapped_c & (~stage_valid | per_gnt_i) &
                        (in_flight_c < IFL_W'(MAX_OUTSTANDING));
   // Local error only when idle, so it can never overtake or collide with a demux response
   assign acc_err_c   = core_req_i & ~mapped_c & (in_flight_c == '0) & ~err_pend;
   assign cnt_inc_c   = stage_valid & per_gnt_i;

   assign core_gnt_o  = acc_map_c | acc_err_c;
   assign per_req_o   = stage_valid;
   assign per_add_o   = add_q;
   assign per_wen_o   = wen_q;
   assign per_wdata_o = wdata_q;
   assign per_be_o    = be_q;

   assign core_r_valid_o = err_pend ? 1'b1 : per_r_valid_i;
   assign core_r_opc_o   = err_pend ? 1'b1 : per_r_opc_i;
   assign core_r_rdata_o = err_pend ? '0   : per_r_rdata_i;

   // Request stage, in-flight counter and pending local error
   always_ff @(posedge clk or negedge rst_ni) begin
      if (!rst_ni) begin
         stage_valid <= 1'b0;
         add_q       <= '0;
         wen_q       <= 1'b0;
         wdata_q     <= '0;
         be_q        <= '0;
         out_cnt     <= '0;
         err_pend    <= 1'b0;
      end else begin
         if (acc_map_c) begin
            stage_valid <= 1'b1;
            add_q       <= core_add_i;
            wen_q       <= core_wen_i;
            wdata_q     <= core_wdata_i;
            be_q        <= core_be_i;
         end else if (stage_valid && per_gnt_i) begin
            stage_valid <= 1'b0;
         end
         err_pend <= acc_err_c;
         if (cnt_inc_c && !per_r_valid_i) begin
            out_cnt <= out_cnt + CNT_W'(1);
         end else if (!cnt_inc_c && per_r_valid_i && (out_cnt != '0)) begin
            out_cnt <= out_cnt - CNT_W'(1);
         end
      end
   end

`ifdef PERIPH_REQ_BRIDGE_TIMEOUT_EN
   logic [15:0] wd_cnt;
   logic        timeout_q;

   // Watchdog on responses; observes only, never alters transaction state
   always_ff @(posedge clk or negedge rst_ni) begin
      if (!rst_ni) begin
         wd_cnt    <= '0;
         timeout_q <= 1'b0;
      end else begin
         timeout_q <= 1'b0;
         if ((out_cnt == '0) || per_r_valid_i) begin
            wd_cnt <= '0;
         end else if (wd_cnt == 16'(TIMEOUT_CYCLES - 1)) begin
            wd_cnt    <= '0;
            timeout_q <= 1'b1;
         end else begin
            wd_cnt <= wd_cnt + 16'd1;
         end
      end
   end

   assign timeout_o = timeout_q;
`else
   logic unused_to_c;
   assign unused_to_c = |TIMEOUT_CYCLES;
   assign timeout_o   = 1'b0;
`endif

endmodule

// File: tb/tb_periph_req_bridge.sv
// Directed bench for periph_req_bridge: decode table plus hand sequences for
// flow control, stall stability, in-flight cap and the optional watchdog.
module tb_periph_req_bridge;

   logic        clk = 1'b0;
   logic        rst_ni;
   logic        core_req_i;
   logic [31:0] core_add_i;
   logic        core_wen_i;
   logic [31:0] core_wdata_i;
   logic [3:0]  core_be_i;
   logic        core_gnt_o;
   logic        core_r_valid_o;
   logic [31:0] core_r_rdata_o;
   logic        core_r_opc_o;
   logic        per_req_o;
   logic [31:0] per_add_o;
   logic        per_wen_o;
   logic [31:0] per_wdata_o;
   logic [3:0]  per_be_o;
   logic        per_gnt_i;
   logic        per_r_valid_i;
   logic [31:0] per_r_rdata_i;
   logic        per_r_opc_i;
   logic        timeout_o;

   int checks = 0;
   int errors = 0;

`ifdef PERIPH_REQ_BRIDGE_TIMEOUT_EN
   localparam logic TO_EN = 1'b1;
`else
   localparam logic TO_EN = 1'b0;
`endif

   periph_req_bridge #(
      .ADDR_WIDTH(32), .DATA_WIDTH(32), .BE_WIDTH(4),
      .DEM_PER_BEFORE_TCDM_TS(1'b0), .MAX_OUTSTANDING(2), .TIMEOUT_CYCLES(8)
   ) dut (
      .clk(clk), .rst_ni(rst_ni),
      .core_req_i(core_req_i), .core_add_i(core_add_i), .core_wen_i(core_wen_i),
      .core_wdata_i(core_wdata_i), .core_be_i(core_be_i), .core_gnt_o(core_gnt_o),
      .core_r_valid_o(core_r_valid_o), .core_r_rdata_o(core_r_rdata_o),
      .core_r_opc_o(core_r_opc_o),
      .per_req_o(per_req_o), .per_add_o(per_add_o), .per_wen_o(per_wen_o),
      .per_wdata_o(per_wdata_o), .per_be_o(per_be_o), .per_gnt_i(per_gnt_i),
      .per_r_valid_i(per_r_valid_i), .per_r_rdata_i(per_r_rdata_i),
      .per_r_opc_i(per_r_opc_i), .timeout_o(timeout_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] add;
      logic        wen;
      logic [31:0] wdata;
      logic [3:0]  be;
      logic [31:0] rdata;
      logic        ropc;
      logic        mapped;
   } vec_t;

   vec_t vecs[7];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_in();
      core_req_i    = 1'b0;
      core_add_i    = '0;
      core_wen_i    = 1'b0;
      core_wdata_i  = '0;
      core_be_i     = '0;
      per_gnt_i     = 1'b0;
      per_r_valid_i = 1'b0;
      per_r_rdata_i = '0;
      per_r_opc_i   = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "time limit");
   end

   initial begin
      int ng;
      vecs[0] = '{32'h1020_4000, 1'b1, 32'h0000_0000, 4'hF, 32'hDEAD_BEEF, 1'b0, 1'b1};
      vecs[1] = '{32'h1020_4800, 1'b0, 32'h1234_5678, 4'h3, 32'h0000_0000, 1'b0, 1'b0};
      vecs[2] = '{32'h1020_4400, 1'b0, 32'hA5A5_0F0F, 4'h9, 32'h0000_0000, 1'b0, 1'b1};
      vecs[3] = '{32'h1020_7C00, 1'b1, 32'h0000_0000, 4'hF, 32'h0000_0000, 1'b0, 1'b0};
      vecs[4] = '{32'h0000_4000, 1'b1, 32'h0000_0000, 4'hF, 32'h0BAD_F00D, 1'b1, 1'b1};
      vecs[5] = '{32'h1020_0000, 1'b1, 32'h0000_0000, 4'hF, 32'h0000_0000, 1'b0, 1'b0};
      vecs[6] = '{32'h1020_C000, 1'b0, 32'hFFFF_0000, 4'hC, 32'h0000_0000, 1'b0, 1'b0};

      idle_in();
      rst_ni = 1'b0;
      step();
      step();
      chk("rst_per_req", per_req_o, 0);
      chk("rst_per_add", per_add_o, 0);
      chk("rst_per_wdata", per_wdata_o, 0);
      chk("rst_r_valid", core_r_valid_o, 0);
      chk("rst_r_opc", core_r_opc_o, 0);
      chk("rst_r_rdata", core_r_rdata_o, 0);
      chk("rst_timeout", timeout_o, 0);
      rst_ni = 1'b1;
      step();

      // Decode table: each vector starts and ends with the bridge idle
      for (int i = 0; i < 7; i++) begin
         core_req_i   = 1'b1;
         core_add_i   = vecs[i].add;
         core_wen_i   = vecs[i].wen;
         core_wdata_i = vecs[i].wdata;
         core_be_i    = vecs[i].be;
         #1 chk($sformatf("v%0d_gnt", i), core_gnt_o, 1);
         step();
         core_req_i    = 1'b0;
         core_add_i    = '0;
         per_r_rdata_i = 32'h5555_AAAA;
         #1;
         if (vecs[i].mapped) begin
            chk($sformatf("v%0d_per_req", i), per_req_o, 1);
            chk($sformatf("v%0d_per_add", i), per_add_o, vecs[i].add);
            chk($sformatf("v%0d_per_wen", i), per_wen_o, vecs[i].wen);
            chk($sformatf("v%0d_per_wdata", i), per_wdata_o, vecs[i].wdata);
            chk($sformatf("v%0d_per_be", i), per_be_o, vecs[i].be);
            chk($sformatf("v%0d_no_rsp", i), core_r_valid_o, 0);
            per_gnt_i = 1'b1;
            step();
            per_gnt_i = 1'b0;
            #1 chk($sformatf("v%0d_req_clr", i), per_req_o, 0);
            step();
            per_r_valid_i = 1'b1;
            per_r_rdata_i = vecs[i].rdata;
            per_r_opc_i   = vecs[i].ropc;
            #1 chk($sformatf("v%0d_r_valid", i), core_r_valid_o, 1);
            chk($sformatf("v%0d_r_rdata", i), core_r_rdata_o, vecs[i].rdata);
            chk($sformatf("v%0d_r_opc", i), core_r_opc_o, vecs[i].ropc);
            step();
            per_r_valid_i = 1'b0;
            per_r_opc_i   = 1'b0;
         end else begin
            chk($sformatf("v%0d_no_fwd", i), per_req_o, 0);
            chk($sformatf("v%0d_err_valid", i), core_r_valid_o, 1);
            chk($sformatf("v%0d_err_opc", i), core_r_opc_o, 1);
            chk($sformatf("v%0d_err_rdata", i), core_r_rdata_o, 0);
            step();
            #1 chk($sformatf("v%0d_err_once", i), core_r_valid_o, 0);
         end
      end
      idle_in();
      step();

      // Unmapped request waits for the outstanding mapped read
      core_req_i = 1'b1;
      core_add_i = 32'h1020_4000;
      core_wen_i = 1'b1;
      #1 chk("a_map_gnt", core_gnt_o, 1);
      step();
      core_add_i = 32'h1020_4800;
      per_gnt_i  = 1'b1;
      #1 chk("a_unmap_blk0", core_gnt_o, 0);
      step();
      per_gnt_i = 1'b0;
      for (int k = 0; k < 3; k++) begin
         #1 chk($sformatf("a_unmap_blk%0d", k + 1), core_gnt_o, 0);
         step();
      end
      per_r_valid_i = 1'b1;
      per_r_rdata_i = 32'h1111_2222;
      #1 chk("a_blk_same_rsp", core_gnt_o, 0);
      chk("a_rsp_valid", core_r_valid_o, 1);
      chk("a_rsp_opc", core_r_opc_o, 0);
      step();
      per_r_valid_i = 1'b0;
      #1 chk("a_unmap_gnt", core_gnt_o, 1);
      step();
      core_req_i = 1'b0;
      #1 chk("a_err_valid", core_r_valid_o, 1);
      chk("a_err_opc", core_r_opc_o, 1);
      chk("a_err_rdata", core_r_rdata_o, 0);
      step();
      idle_in();

      // Back-to-back up to the in-flight cap, then reopen on one response
      per_gnt_i  = 1'b1;
      core_req_i = 1'b1;
      core_add_i = 32'h1020_4000;
      core_wen_i = 1'b1;
      ng = 0;
      for (int k = 0; k < 5; k++) begin
         #1 ng += int'(core_gnt_o);
         step();
      end
      chk("b_grant_count", ng, 2);
      per_r_valid_i = 1'b1;
      #1 chk("b_no_gnt_same_rsp", core_gnt_o, 0);
      step();
      per_r_valid_i = 1'b0;
      #1 chk("b_gnt_reopen", core_gnt_o, 1);
      step();
      core_req_i = 1'b0;
      step();
      per_gnt_i     = 1'b0;
      per_r_valid_i = 1'b1;
      step();
      step();
      per_r_rdata_i = 32'h7777_0000;
      #1 chk("b_stray_valid", core_r_valid_o, 1);
      chk("b_stray_rdata", core_r_rdata_o, 32'h7777_0000);
      step();
      per_r_valid_i = 1'b0;
      core_req_i    = 1'b1;
      core_add_i    = 32'h1020_0000;
      #1 chk("b_idle_after_stray", core_gnt_o, 1);
      step();
      core_req_i = 1'b0;
      #1 chk("b_err_valid", core_r_valid_o, 1);
      step();
      idle_in();

      // Staged write held stable while the demux stalls
      core_req_i   = 1'b1;
      core_add_i   = 32'h1020_4400;
      core_wen_i   = 1'b0;
      core_wdata_i = 32'hCAFE_F00D;
      core_be_i    = 4'h5;
      #1 chk("c_gnt", core_gnt_o, 1);
      step();
      core_add_i   = 32'h1020_4000;
      core_wen_i   = 1'b1;
      core_wdata_i = 32'h0;
      core_be_i    = 4'hF;
      for (int k = 0; k < 5; k++) begin
         #1 chk($sformatf("c_stall%0d_add", k), per_add_o, 32'h1020_4400);
         chk($sformatf("c_stall%0d_wdata", k), per_wdata_o, 32'hCAFE_F00D);
         chk($sformatf("c_stall%0d_be", k), per_be_o, 4'h5);
         chk($sformatf("c_stall%0d_req", k), per_req_o, 1);
         chk($sformatf("c_stall%0d_gnt", k), core_gnt_o, 0);
         step();
      end
      per_gnt_i = 1'b1;
      #1 chk("c_gnt_on_pergnt", core_gnt_o, 1);
      step();
      core_req_i = 1'b0;
      #1 chk("c_next_add", per_add_o, 32'h1020_4000);
      chk("c_next_wen", per_wen_o, 1);
      step();
      per_gnt_i     = 1'b0;
      per_r_valid_i = 1'b1;
      step();
      step();
      idle_in();
      step();

      // Watchdog: pulses 8 and 16 cycles after downstream grant when built in
      core_req_i = 1'b1;
      core_add_i = 32'h1020_4000;
      core_wen_i = 1'b1;
      step();
      core_req_i = 1'b0;
      per_gnt_i  = 1'b1;
      step();
      per_gnt_i = 1'b0;
      for (int c = 1; c <= 16; c++) begin
         step();
         chk($sformatf("d_timeout_c%0d", c), timeout_o,
             64'(TO_EN & ((c == 8) || (c == 16))));
      end
      rst_ni = 1'b0;
      #1 chk("d_rst_timeout", timeout_o, 0);
      chk("d_rst_per_req", per_req_o, 0);
      step();
      rst_ni     = 1'b1;
      core_req_i = 1'b1;
      core_add_i = 32'h1020_4800;
      #1 chk("d_rst_cnt_clear", core_gnt_o, 1);
      step();
      core_req_i = 1'b0;
      #1 chk("d_err_after_rst", core_r_valid_o, 1);
      step();
      idle_in();
      step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
